// File: rtl/scan_sequencer_3bit.sv
// Steps a 3-bit decoder select through the set bits of a captured channel mask, holding each for dwell+1 cycles.
// Outputs are registered; the first index appears the cycle after start, there is no backpressure.
module scan_sequencer_3bit #(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [7:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [2:0]         i_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [2:0]         i_q, i_d;
  logic               done_q, done_d;

  logic [2:0] first_in;
  logic [2:0] first_q;
  logic [2:0] next_q;
  logic       next_found;

  // Descending loops so the last hit written is the lowest qualifying bit.
  always_comb begin
    first_in   = '0;
    first_q    = '0;
    next_q     = '0;
    next_found = 1'b0;
    for (int n = 7; n >= 0; n--) begin
      if (mask_i[n]) first_in = 3'(n);
      if (mask_q[n]) first_q = 3'(n);
      if (mask_q[n] && (3'(n) > i_q)) begin
        next_q     = 3'(n);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    i_d     = i_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i && (mask_i != 8'h00)) begin
          mask_d  = mask_i;
          dwell_d = dwell_i;
          mode_d  = mode_i;
          i_d     = first_in;
          cnt_d   = dwell_i;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (next_found) begin
          i_d   = next_q;
          cnt_d = dwell_q;
        end else if (!mode_q) begin
          i_d   = first_q;
          cnt_d = dwell_q;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      i_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      done_q  <= done_d;
    end
  end

  assign i_o     = i_q;
  assign valid_o = (state_q == SCAN);
  assign busy_o  = (state_q == SCAN);
  assign done_o  = done_q;

endmodule
